// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Define MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
`timescale 1ns/1ps
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   shifted;

`ifdef MUL_EARLY_TERM_EN
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   aligned;
`endif

  assign a_mag = (is_signed && A[WIDTH-1]) ? -A : A;
  assign b_mag = (is_signed && B[WIDTH-1]) ? -B : B;

  // Upper half accumulates; the multiplier sits in the lower half and shifts out LSB first.
  assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign shifted = {sum, acc_q[WIDTH-1:1]};

  assign P = p_q;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    p_d       = p_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef MUL_EARLY_TERM_EN
    mplier_d  = mplier_q;
    aligned   = shifted >> (LAST - cnt_q);
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          neg_d   = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          mcand_d = a_mag;
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          cnt_d   = '0;
          state_d = CALC;
`ifdef MUL_EARLY_TERM_EN
          mplier_d = b_mag;
`endif
        end
      end
      CALC: begin
        acc_d = shifted;
        cnt_d = cnt_q + 1'b1;
`ifdef MUL_EARLY_TERM_EN
        mplier_d = mplier_q >> 1;
        // Unconsumed bits are zero: drop the not-yet-shifted low zeros to align the product.
        if (mplier_q[WIDTH-1:1] == '0) begin
          p_d     = neg_q ? -aligned : aligned;
          state_d = DONE;
        end
`else
        if (cnt_q == LAST) begin
          p_d     = neg_q ? -shifted : shifted;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
`ifdef MUL_EARLY_TERM_EN
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
`ifdef MUL_EARLY_TERM_EN
      mplier_q <= mplier_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=32): scoreboard of expected products, latency and handshake checks.
`timescale 1ns/1ps
module tb_seq_multiplier;

  localparam int W = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    A;
  logic [W-1:0]    B;
  logic            is_signed;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  P;

  int n_vec;
  int n_err;
  logic [2*W-1:0] exp_q[$];

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [63:0] sa, sb, sp;
    if (s) begin
      sa = $signed({{W{a[W-1]}}, a});
      sb = $signed({{W{b[W-1]}}, b});
      sp = sa * sb;
      return sp;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  function automatic int exp_lat(input logic [W-1:0] b, input logic s);
`ifdef MUL_EARLY_TERM_EN
    logic [W-1:0] m;
    int hb;
    m  = (s && b[W-1]) ? -b : b;
    hb = 0;
    for (int i = 0; i < W; i++) if (m[i]) hb = i;
    return hb + 1;
`else
    return W;
`endif
  endfunction

  // One full operation: accept, count latency, check P, optionally stall the consumer.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [63:0] expv, input int hold);
    int lat;
    bit done;
    logic [63:0] e;
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    A = a; B = b; is_signed = s; in_valid = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; is_signed = ~s;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 3) begin in_valid = 1'b1; A = $urandom; B = $urandom; end
      if (lat == 6) in_valid = 1'b0;
      if (out_valid) done = 1'b1;
    end
    in_valid = 1'b0;
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(b, s)));
    e = exp_q.pop_front();
    chk({tag, "_p"}, P, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_v"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_hold_p"}, P, e);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ov_low"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_ir_high"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    logic rs;
    n_vec = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_p", P, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("u3x4",   32'd3,         32'd4,         1'b0, 64'h0000_0000_0000_000C, 0);
    run_op("uffff",  32'h0000FFFF,  32'h0000AAAA,  1'b0, 64'h0000_0000_AAA9_5556, 0);
    run_op("ubig",   32'h12345678,  32'h87654321,  1'b0, 64'h09A0_CD05_70B8_8D78, 10);
    run_op("uall1",  32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 64'hFFFF_FFFE_0000_0001, 0);
    run_op("sall1",  32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 64'h0000_0000_0000_0001, 0);
    run_op("s1xm1",  32'h00000001,  32'hFFFFFFFF,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("smin2",  32'h80000000,  32'h80000000,  1'b1, 64'h4000_0000_0000_0000, 0);
    run_op("zero",   32'h00000000,  32'h12345678,  1'b0, 64'd0, 0);
    run_op("bzero",  32'h12345678,  32'h00000000,  1'b1, 64'd0, 0);

    for (int k = 0; k < 8; k++) begin
      ra = $urandom; rb = $urandom; rs = k[0];
      if (k == 2) rb = rb >> 20;
      run_op("rand", ra, rb, rs, model(ra, rb, rs), k == 5 ? 3 : 0);
    end

    // Abort mid-CALC: reset at the fifth CALC cycle must drop the operation.
    A = 32'd5; B = 32'h8000_0003; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_p", P, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", 64'(seen), 64'd0);

    run_op("post", 32'h0000_1234, 32'hFFFF_FFFE, 1'b1, model(32'h0000_1234, 32'hFFFF_FFFE, 1'b1), 0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
